tx_sched: RTL

TX_SCHED -- requirements
Module: tx_sched

---
 rtl/tx_sched_pkg.sv | 38 +++
 rtl/tx_baud_gen.sv | 38 +++
 rtl/tx_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/tx_sched_pkg.sv
// Shared definitions for the transmit scheduler.
// Holds the FSM state encoding, the channel count and id width, the default
// packet header base, and the round-robin pick helper used by the arbiter.
package tx_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int ID_W   = 2;

  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_t;

  // First eligible channel scanning upward from (last + 1), wrapping at NUM_CH.
  // Returns 'last' when nothing is eligible; callers only use it when eligible != 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_CH-1:0] eligible,
                                              input logic [ID_W-1:0]   last);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last + ID_W'(k);
      if (!found && eligible[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tx_baud_gen.sv
// Free-running bit-rate enable generator.
// Ports:
//   clk_12m   - system clock
//   rst_n     - asynchronous active-low reset
//   tx_clken  - one-cycle pulse every BAUD_DIV cycles (high while count = BAUD_DIV-1)
module tx_baud_gen #(
  parameter int BAUD_DIV = 104
) (
  input  logic clk_12m,
  input  logic rst_n,
  output logic tx_clken
);

  localparam logic [11:0] CNT_LAST = 12'(BAUD_DIV - 1);
  // The enable is registered, so it is set one count early to line up with CNT_LAST.
  localparam logic [11:0] CNT_PRE  = 12'(BAUD_DIV - 2);

  logic [11:0] count_reg;
  logic [11:0] count_next;
  logic        clken_reg;

  always_comb begin
    count_next = (count_reg == CNT_LAST) ? 12'd0 : count_reg + 12'd1;
  end

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 12'd0;
      clken_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      clken_reg <= (count_reg == CNT_PRE);
    end
  end

  assign tx_clken = clken_reg;

endmodule

// File: rtl/tx_sched.sv
// Four-channel packet scheduler feeding a single serial transmitter.
// Arbitrates round-robin among enabled channels, sends a header byte
// (HDR_BASE | channel id) followed by the channel's bytes until req_last,
// and paces every write on the transmitter's busy handshake.
// Ports:
//   clk_12m, rst_n       - clock, asynchronous active-low reset
//   req_valid/data/last  - per-channel byte stream (channel i on data[8i+7:8i])
//   req_mask             - per-channel enable for arbitration
//   req_ready            - one-hot pulse: the granted channel's byte was consumed
//   tx_din, tx_wr_en     - byte and write strobe to the transmitter
//   tx_clken             - bit-rate enable to the transmitter
//   tx_busy              - transmitter busy flag
//   grant, pkt_active    - current link owner and packet-in-progress flag
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter int         BAUD_DIV = 104,
  parameter logic [7:0] HDR_BASE = HDR_BASE_DEFAULT
) (
  input  logic                clk_12m,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   req_valid,
  input  logic [8*NUM_CH-1:0] req_data,
  input  logic [NUM_CH-1:0]   req_last,
  input  logic [NUM_CH-1:0]   req_mask,
  output logic [NUM_CH-1:0]   req_ready,
  output logic [7:0]          tx_din,
  output logic                tx_wr_en,
  output logic                tx_clken,
  input  logic                tx_busy,
  output logic [ID_W-1:0]     grant,
  output logic                pkt_active
);

  state_t              state_reg;
  logic [ID_W-1:0]     grant_reg;
  logic [ID_W-1:0]     last_grant_reg;
  logic                last_sent_reg;
  logic                pkt_active_reg;
  logic [7:0]          tx_din_reg;
  logic                tx_wr_en_reg;
  logic [NUM_CH-1:0]   req_ready_reg;

  logic [NUM_CH-1:0]   eligible;
  logic [NUM_CH-1:0]   grant_onehot;
  logic [7:0]          ch_byte [NUM_CH];

  tx_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk_12m  (clk_12m),
    .rst_n    (rst_n),
    .tx_clken (tx_clken)
  );

  assign eligible = req_valid & req_mask;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_byte[gi]      = req_data[8*gi +: 8];
    assign grant_onehot[gi] = (grant_reg == ID_W'(gi));
  end

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= ID_W'(NUM_CH - 1);
      last_sent_reg  <= 1'b0;
      pkt_active_reg <= 1'b0;
      tx_din_reg     <= 8'h00;
      tx_wr_en_reg   <= 1'b0;
      req_ready_reg  <= '0;
    end else begin
      tx_wr_en_reg  <= 1'b0;
      req_ready_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (|eligible) begin
            grant_reg <= rr_pick(eligible, last_grant_reg);
            state_reg <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!tx_busy) begin
            tx_din_reg     <= HDR_BASE | {{(8-ID_W){1'b0}}, grant_reg};
            tx_wr_en_reg   <= 1'b1;
            pkt_active_reg <= 1'b1;
            last_sent_reg  <= 1'b0;
            state_reg      <= ST_WAIT_HI;
          end
        end
        ST_DATA: begin
          // The owner keeps the link while its stream stalls; mask changes
          // are only seen by the arbiter in IDLE.
          if (!tx_busy && req_valid[grant_reg]) begin
            tx_din_reg    <= ch_byte[grant_reg];
            tx_wr_en_reg  <= 1'b1;
            req_ready_reg <= grant_onehot;
            last_sent_reg <= req_last[grant_reg];
            state_reg     <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          // Waiting for busy to rise guarantees one strobe per busy period.
          if (tx_busy) begin
            state_reg <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (last_sent_reg) begin
              last_grant_reg <= grant_reg;
              pkt_active_reg <= 1'b0;
              state_reg      <= ST_IDLE;
            end else begin
              state_reg <= ST_DATA;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign tx_din     = tx_din_reg;
  assign tx_wr_en   = tx_wr_en_reg;
  assign grant      = grant_reg;
  assign pkt_active = pkt_active_reg;

endmodule
